ifetch_pc: RTL and testbench

Instruction-fetch front end: owns the architectural PC register, fetches the instruction at PC from instruction memory over a req/ack handshake, and presents it to decode/execute with a valid/ready handshake. Sits directly upstream of the next-PC logic: `pc_o` feeds its PC input, and its next-PC result returns on `npc_i`. That result is loaded into PC only when the current instruction is accepted. It also checks word alignment of the next PC and counts retired instructions.

---
 rtl/ifetch_pc.sv | 58 +++++
 tb/tb_ifetch_pc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ifetch_pc.sv
// ifetch_pc: PC register, instruction fetch over req/ack and valid/ready hand-off to decode
module ifetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic        misalign_o,
    output logic [31:0] retired_cnt_o
);
    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;
    state_t state, state_nxt;
    logic ack, accept;
    assign ack          = state == REQ && imem_ack_i;
    assign accept       = state == VALID && inst_ready_i;
    assign imem_req_o   = state == REQ;
    assign inst_valid_o = state == VALID;
    assign imem_addr_o  = pc_o;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    // next state: idle lasts one cycle, ack moves to valid, accept refetches
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = REQ;
            REQ:     state_nxt = ack ? VALID : REQ;
            VALID:   state_nxt = accept ? REQ : VALID;
            default: state_nxt = IDLE;
        endcase
    end
    // datapath: capture instruction on ack, advance pc and retire count on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o          <= RESET_PC;
            inst_o        <= '0;
            retired_cnt_o <= '0;
            misalign_o    <= 1'b0;
        end else begin
            misalign_o <= accept && npc_i[1:0] != 2'b00;
            if (ack)
                inst_o <= imem_rdata_i;
            if (accept) begin
                pc_o          <= npc_i[1:0] == 2'b00 ? npc_i : EXC_VEC;
                retired_cnt_o <= retired_cnt_o + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_pc.sv
// tb_ifetch_pc: directed checks of boot, fetch, stalls, redirects, reset and counter wrap
module tb_ifetch_pc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        misalign_o;
    logic [31:0] retired_cnt_o;
    int n_checks = 0;
    int n_fail = 0;

    ifetch_pc dut (
        .clk(clk), .rst(rst), .npc_i(npc_i), .pc_o(pc_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .misalign_o(misalign_o), .retired_cnt_o(retired_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic req, input logic vld, input logic mis);
        chk({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, req});
        chk({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, vld});
        chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, mis});
    endtask

    initial begin
        rst = 1'b1;
        npc_i = '0;
        imem_ack_i = 1'b0;
        imem_rdata_i = '0;
        inst_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_ctl("reset", 1'b0, 1'b0, 1'b0);
            chk("reset.pc", pc_o, 32'h3000);
            chk("reset.inst", inst_o, 32'h0);
            chk("reset.cnt", retired_cnt_o, 32'h0);
        end
        rst = 1'b0;
        chk_ctl("boot.idle", 1'b0, 1'b0, 1'b0);
        cyc();
        chk_ctl("boot.req", 1'b1, 1'b0, 1'b0);
        chk("boot.addr", imem_addr_o, 32'h3000);
        // sequential zero-wait fetch
        for (int i = 0; i < 3; i++) begin
            imem_ack_i = 1'b1;
            imem_rdata_i = 32'hA000_0000 + i;
            inst_ready_i = 1'b1;
            chk("seq.addr", imem_addr_o, 32'h3000 + 4 * i);
            cyc();
            chk_ctl("seq.valid", 1'b0, 1'b1, 1'b0);
            chk("seq.inst", inst_o, 32'hA000_0000 + i);
            imem_ack_i = 1'b0;
            npc_i = 32'h3004 + 4 * i;
            cyc();
            chk_ctl("seq.req", 1'b1, 1'b0, 1'b0);
            chk("seq.pc", pc_o, 32'h3004 + 4 * i);
            chk("seq.cnt", retired_cnt_o, i + 1);
        end
        // wait states, with ready asserted in REQ which must be ignored
        inst_ready_i = 1'b1;
        npc_i = 32'h3100;
        imem_rdata_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_ctl("wait", 1'b1, 1'b0, 1'b0);
            chk("wait.addr", imem_addr_o, 32'h300C);
            chk("wait.cnt", retired_cnt_o, 32'd3);
        end
        inst_ready_i = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hB000_0000;
        cyc();
        chk_ctl("wack", 1'b0, 1'b1, 1'b0);
        chk("wack.inst", inst_o, 32'hB000_0000);
        // backpressure, with a stray ack that must be ignored
        imem_rdata_i = 32'hDEAD_BEEF;
        npc_i = 32'h0000_0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_ctl("bp", 1'b0, 1'b1, 1'b0);
            chk("bp.inst", inst_o, 32'hB000_0000);
            chk("bp.pc", pc_o, 32'h300C);
            chk("bp.cnt", retired_cnt_o, 32'd3);
        end
        // branch target
        imem_ack_i = 1'b0;
        inst_ready_i = 1'b1;
        npc_i = 32'h3040;
        cyc();
        chk_ctl("br", 1'b1, 1'b0, 1'b0);
        chk("br.addr", imem_addr_o, 32'h3040);
        chk("br.cnt", retired_cnt_o, 32'd4);
        // misaligned target
        inst_ready_i = 1'b0;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hC000_0000;
        cyc();
        chk_ctl("mis.fetch", 1'b0, 1'b1, 1'b0);
        imem_ack_i = 1'b0;
        inst_ready_i = 1'b1;
        npc_i = 32'h3042;
        cyc();
        chk_ctl("mis.pulse", 1'b1, 1'b0, 1'b1);
        chk("mis.pc", pc_o, 32'h4180);
        chk("mis.cnt", retired_cnt_o, 32'd5);
        inst_ready_i = 1'b0;
        cyc();
        chk_ctl("mis.after", 1'b1, 1'b0, 1'b0);
        chk("mis.addr", imem_addr_o, 32'h4180);
        // reset in REQ with ack in the same cycle, ack held into IDLE
        rst = 1'b1;
        imem_ack_i = 1'b1;
        imem_rdata_i = 32'hEEEE_EEEE;
        cyc();
        chk_ctl("mrst", 1'b0, 1'b0, 1'b0);
        chk("mrst.pc", pc_o, 32'h3000);
        chk("mrst.inst", inst_o, 32'h0);
        chk("mrst.cnt", retired_cnt_o, 32'h0);
        rst = 1'b0;
        cyc();
        chk_ctl("mrst.idle_ack", 1'b1, 1'b0, 1'b0);
        chk("mrst.inst2", inst_o, 32'h0);
        // counter wrap
        imem_rdata_i = 32'hF000_0000;
        cyc();
        chk_ctl("wrap.fetch", 1'b0, 1'b1, 1'b0);
        chk("wrap.inst", inst_o, 32'hF000_0000);
        imem_ack_i = 1'b0;
        force dut.retired_cnt_o = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_o;
        inst_ready_i = 1'b1;
        npc_i = 32'h3004;
        cyc();
        chk("wrap.cnt", retired_cnt_o, 32'h0);
        chk("wrap.pc", pc_o, 32'h3004);
        chk_ctl("wrap.req", 1'b1, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
